spdif_tx_core: RTL and testbench
================================

SPDIF_TX_CORE -- requirements
Module: spdif_tx_core

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 24, audio bits per channel, legal 16..24.
REQ-002 SHALL have parameter CLK_DIV, default 1, clock cycles per biphase half-cell, legal 1..255.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, stereo-pair FIFO entries, power of two, 2..64.
REQ-004 SHALL have parameter CS_WORD, default 32'h0000_0004, channel-status bits 0..31 (bit i = CS_WORD[i]).
REQ-005 i2s_bclk_pll  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 sample_left  input  SAMPLE_WIDTH  left sample, two's complement.
REQ-008 sample_right  input  SAMPLE_WIDTH  right sample, two's complement.
REQ-009 sample_valid  input  1  producer offers the pair.
REQ-010 sample_ready  output  1  FIFO can accept; push = sample_valid & sample_ready.
REQ-011 spdif_out  output  1  biphase-mark S/PDIF line, registered.
REQ-012 block_start  output  1  one-cycle pulse on the first half-cell of frame 0.
REQ-013 underrun  output  1  one-cycle pulse when a frame starts with the FIFO empty.

Function
REQ-014 Timing: half-cell = CLK_DIV cycles; slot = 2 half-cells; subframe = 32 slots; frame = left + right subframe = 128 half-cells = 128*CLK_DIV cycles.
REQ-015 Frame counter 0..191, wraps 191->0; block_start pulses when frame 0 begins.
REQ-016 Preamble (slots 0-3, 8 half-cells), levels given for preceding level 0: B=11101000 (left, frame 0), M=11100010 (left, other frames), W=11100100 (right); when preceding level is 1, all 8 levels inverted.
REQ-017 Slots 4..27: audio LSB-first; sample MSB in slot 27, sample LSB in slot 28-SAMPLE_WIDTH, slots below it 0.
REQ-018 Slot 28 V: 0 for FIFO data, 1 for underrun filler; slot 29 U = 0; slot 30 C = channel-status bit at current frame index (0 for index >= 32), identical in both subframes.
REQ-019 Slot 31 P: even parity over slots 4..31 (count of ones in 4..31 is even).
REQ-020 Slots 4..31 biphase-mark: level inverts at every slot start; inverts again at mid-slot when bit = 1.
REQ-021 FIFO: sample_ready = not full; push when not full; pop on first cycle of each frame when not empty; simultaneous push and pop permitted, count unchanged.
REQ-022 No bypass: pair pushed on the frame-start cycle into empty FIFO is not used; that frame underruns; pair sent next frame.
REQ-023 Underrun frame: both samples 0, V=1 in both subframes, underrun pulses once at frame start; framing, frame counter and channel status unaffected.
REQ-024 Latency: pair popped at frame start; its left preamble first level appears on spdif_out the following cycle.
REQ-025 Left and right of one pair always transmitted in the same frame; never split.

Reset
REQ-026 While rst high: spdif_out=0, sample_ready=0, block_start=0, underrun=0, FIFO empty, frame/slot/half-cell counters 0.
REQ-027 First cycle after rst release: frame 0 starts (B preamble, preceding level 0); sample_ready=1; underrun pulses (FIFO empty); block_start pulses.
REQ-028 rst asserted mid-frame: output forced to 0 immediately, FIFO contents discarded, no partial frame resumed.

Verification
REQ-029 Idle after reset, CLK_DIV=1: spdif_out first 8 cycles 11101000; frame length 128 cycles; V=1 both subframes; underrun pulses every 128 cycles.
REQ-030 SAMPLE_WIDTH=24, push L=24'h800001, R=24'h000000: left slots 4 and 27 = 1, others 0, P=0; right all-zero audio, P=0; V=0; decoded samples match.
REQ-031 SAMPLE_WIDTH=16, L=16'hFFFF: slots 4..11 = 0, slots 12..27 = 1, P=0; decoded left = 24'hFFFF00.
REQ-032 FIFO_DEPTH=4, hold sample_valid high with no frame boundary: exactly 4 pushes, sample_ready low; ready returns high one cycle after next pop; order preserved.
REQ-033 192 frames run: block_start pulses at frames 0 and 192 only; B preamble only there; C bits over a block equal CS_WORD then 160 zeros.
REQ-034 CLK_DIV=3, rst pulsed mid-right-subframe with 2 pairs queued: spdif_out 0 during rst, restart with B at frame 0, underrun pulse, queued pairs never transmitted.

Source files
------------

// File: rtl/spdif_tx_core.sv
// S/PDIF (IEC 60958) transmitter: stereo-pair FIFO, 192-frame channel-status block,
// biphase-mark line coding with B/M/W preambles. One half-cell spans CLK_DIV clocks.
module spdif_tx_core #(
    parameter int          SAMPLE_WIDTH = 24,
    parameter int          CLK_DIV      = 1,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] CS_WORD      = 32'h0000_0004
) (
    input  logic                    i2s_bclk_pll,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] sample_left,
    input  logic [SAMPLE_WIDTH-1:0] sample_right,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    spdif_out,
    output logic                    block_start,
    output logic                    underrun
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int DW  = 2 * SAMPLE_WIDTH;
    localparam int PAD = 24 - SAMPLE_WIDTH;

    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    logic [7:0] div_cnt;
    logic [6:0] half_cnt;
    logic [7:0] frame_cnt;
    logic       half_tick;
    logic       frame_start;

    assign half_tick   = (div_cnt == 8'(CLK_DIV - 1));
    assign frame_start = (div_cnt == 8'd0) && (half_cnt == 7'd0);

    // Frame k occupies frame_cnt == k for all of its 128 half-cells.
    always_ff @(posedge i2s_bclk_pll or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            half_cnt  <= '0;
            frame_cnt <= '0;
        end else if (half_tick) begin
            div_cnt <= '0;
            if (half_cnt == 7'd127) begin
                half_cnt  <= '0;
                frame_cnt <= (frame_cnt == 8'd191) ? 8'd0 : frame_cnt + 8'd1;
            end else begin
                half_cnt <= half_cnt + 7'd1;
            end
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count == (PW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    // NOTE: the reset term keeps these outputs low for the whole time rst is held,
    // even though the counters already sit at their frame-start values.
    assign sample_ready = !rst && !full;
    assign block_start  = !rst && frame_start && (frame_cnt == 8'd0);
    assign underrun     = !rst && frame_start && empty;

    assign push = sample_valid && sample_ready;
    assign pop  = frame_start && !empty;

    // NOTE: the sample memory has no reset; count and pointers alone define which entries are live.
    always_ff @(posedge i2s_bclk_pll) begin
        if (push) mem[wr_ptr] <= {sample_left, sample_right};
    end

    always_ff @(posedge i2s_bclk_pll or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Pair in flight; an empty FIFO at frame start sends a zero filler flagged invalid.
    logic [SAMPLE_WIDTH-1:0] cur_left;
    logic [SAMPLE_WIDTH-1:0] cur_right;
    logic                    cur_v;

    always_ff @(posedge i2s_bclk_pll or posedge rst) begin
        if (rst) begin
            cur_left  <= '0;
            cur_right <= '0;
            cur_v     <= 1'b1;
        end else if (frame_start) begin
            if (!empty) begin
                {cur_left, cur_right} <= mem[rd_ptr];
                cur_v                 <= 1'b0;
            end else begin
                cur_left  <= '0;
                cur_right <= '0;
                cur_v     <= 1'b1;
            end
        end
    end

    logic [5:0]              sub_half;
    logic                    right_sub;
    logic [4:0]              slot;
    logic [SAMPLE_WIDTH-1:0] cur_sel;
    logic [23:0]             audio;
    logic                    c_bit;
    logic [31:0]             sub_word;
    logic [7:0]              pre_pat;
    logic                    pre_level;
    logic                    line_next;

    assign sub_half  = half_cnt[5:0];
    assign right_sub = half_cnt[6];
    assign slot      = sub_half[5:1];

    always_comb begin
        cur_sel  = right_sub ? cur_right : cur_left;
        audio    = 24'(cur_sel) << PAD;
        c_bit    = (frame_cnt < 8'd32) ? CS_WORD[frame_cnt[4:0]] : 1'b0;
        sub_word = {^{c_bit, cur_v, audio}, c_bit, 1'b0, cur_v, audio, 4'b0000};
        pre_pat  = right_sub ? PRE_W : ((frame_cnt == 8'd0) ? PRE_B : PRE_M);

        line_next = spdif_out;
        if (sub_half < 6'd8) begin
            // Preamble polarity follows the level that preceded it, latched at its first half-cell.
            if (sub_half == 6'd0) line_next = pre_pat[7] ^ spdif_out;
            else                  line_next = pre_pat[3'd7 - sub_half[2:0]] ^ pre_level;
        end else if (!sub_half[0]) begin
            line_next = ~spdif_out;
        end else begin
            line_next = spdif_out ^ sub_word[slot];
        end
    end

    // Level for half-cell h is registered at its first clock, so it shows one cycle later.
    always_ff @(posedge i2s_bclk_pll or posedge rst) begin
        if (rst) begin
            spdif_out <= 1'b0;
            pre_level <= 1'b0;
        end else if (div_cnt == 8'd0) begin
            spdif_out <= line_next;
            if (sub_half == 6'd0) pre_level <= spdif_out;
        end
    end

endmodule

// File: tb/tb_spdif_tx_core.sv
// Bench for spdif_tx_core: two instances (24-bit/div 1/depth 4 and 16-bit/div 3/depth 2),
// a cycle model of framing and FIFO occupancy, and a line decoder checked against a scoreboard.
module tb_spdif_tx_core;

    localparam logic [31:0] CS    = 32'h8000_0005;
    localparam logic [7:0]  PRE_B = 8'b1110_1000;
    localparam logic [7:0]  PRE_M = 8'b1110_0010;
    localparam logic [7:0]  PRE_W = 8'b1110_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1, sv0 = 1'b0;
    logic [23:0] sl0 = '0, sr0 = '0;
    logic        rdy0, out0, bs0, ur0;

    logic        rst1 = 1'b1, sv1 = 1'b0;
    logic [15:0] sl1 = '0, sr1 = '0;
    logic        rdy1, out1, bs1, ur1;

    spdif_tx_core #(.SAMPLE_WIDTH(24), .CLK_DIV(1), .FIFO_DEPTH(4), .CS_WORD(CS)) u_dut0 (
        .i2s_bclk_pll(clk), .rst(rst0), .sample_left(sl0), .sample_right(sr0),
        .sample_valid(sv0), .sample_ready(rdy0), .spdif_out(out0),
        .block_start(bs0), .underrun(ur0));

    spdif_tx_core #(.SAMPLE_WIDTH(16), .CLK_DIV(3), .FIFO_DEPTH(2), .CS_WORD(CS)) u_dut1 (
        .i2s_bclk_pll(clk), .rst(rst1), .sample_left(sl1), .sample_right(sr1),
        .sample_valid(sv1), .sample_ready(rdy1), .spdif_out(out1),
        .block_start(bs1), .underrun(ur1));

    typedef struct packed {
        logic       v;
        logic [7:0] idx;
    } frame_exp_t;

    // Expected pairs as 24-bit left-justified audio fields, pushed by stimulus on handshake.
    logic [47:0] expq0 [$];
    logic [47:0] expq1 [$];
    frame_exp_t  frq0  [$];
    frame_exp_t  frq1  [$];

    int          total = 0;
    int          bad   = 0;
    bit          stim_done = 1'b0;
    bit          mon_done  = 1'b0;

    int          cd_of    [2] = '{1, 3};
    int          depth_of [2] = '{4, 2};
    int          pos  [2];
    int          frm  [2];
    int          occ  [2];
    int          dpos [2];
    bit          drun [2];
    logic        dprev[2];
    logic [127:0] lv  [2];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic void decode_sub(input logic [127:0] v, input int base, input logic p,
                                       output logic [7:0] pre, output logic [31:0] w,
                                       output int viol);
        logic last;
        for (int i = 0; i < 8; i++) pre[7-i] = v[base+i] ^ p;
        w    = '0;
        viol = 0;
        last = v[base+7];
        for (int s = 4; s < 32; s++) begin
            if (v[base+2*s] == last) viol++;
            w[s] = v[base+2*s] ^ v[base+2*s+1];
            last = v[base+2*s+1];
        end
    endfunction

    task automatic finish_frame(input int l);
        frame_exp_t  fe;
        logic [47:0] pair;
        logic [23:0] a_exp;
        logic [7:0]  pre, pre_exp;
        logic [31:0] w;
        logic [27:0] fld_exp;
        logic        p, cbit;
        int          viol;
        fe   = '{v: 1'b1, idx: 8'd0};
        pair = '0;
        if ((l == 0 ? frq0.size() : frq1.size()) == 0) begin
            check($sformatf("L%0d frame_queue_empty", l), 64'd1, 64'd0);
            return;
        end
        fe = (l == 0) ? frq0.pop_front() : frq1.pop_front();
        if (!fe.v) begin
            if ((l == 0 ? expq0.size() : expq1.size()) == 0)
                check($sformatf("L%0d pair_queue_empty f%0d", l, fe.idx), 64'd1, 64'd0);
            else
                pair = (l == 0) ? expq0.pop_front() : expq1.pop_front();
        end
        cbit = (fe.idx < 8'd32) ? CS[fe.idx[4:0]] : 1'b0;
        for (int sub = 0; sub < 2; sub++) begin
            p       = (sub == 0) ? dprev[l] : lv[l][63];
            pre_exp = (sub == 1) ? PRE_W : ((fe.idx == 8'd0) ? PRE_B : PRE_M);
            a_exp   = (sub == 0) ? pair[47:24] : pair[23:0];
            fld_exp = {^{cbit, fe.v, a_exp}, cbit, 1'b0, fe.v, a_exp};
            decode_sub(lv[l], 64*sub, p, pre, w, viol);
            check($sformatf("L%0d f%0d sub%0d preamble", l, fe.idx, sub), 64'(pre), 64'(pre_exp));
            check($sformatf("L%0d f%0d sub%0d biphase", l, fe.idx, sub), 64'(viol), 64'd0);
            check($sformatf("L%0d f%0d sub%0d slots4_31", l, fe.idx, sub), 64'(w[31:4]), 64'(fld_exp));
        end
        dprev[l] = lv[l][127];
    endtask

    task automatic lane_step(input int l, input logic r, input logic sv, input logic rdy,
                             input logic so, input logic bs, input logic ur);
        int   f, h;
        logic fs, e_rdy, e_ur, e_bs, psh, pp;
        f = 128 * cd_of[l];
        if (r) begin
            check($sformatf("L%0d outputs_in_reset", l), 64'({so, rdy, bs, ur}), 64'd0);
            pos[l] = 0; frm[l] = 0; occ[l] = 0; dpos[l] = 0; drun[l] = 1'b0; dprev[l] = 1'b0;
            if (l == 0) begin expq0.delete(); frq0.delete(); end
            else        begin expq1.delete(); frq1.delete(); end
            return;
        end
        if (drun[l]) begin
            h = dpos[l] / cd_of[l];
            if (dpos[l] % cd_of[l] == 0) lv[l][h] = so;
            else check($sformatf("L%0d half_cell_hold h%0d", l, h), 64'(so), 64'(lv[l][h]));
            dpos[l]++;
            if (dpos[l] == f) begin
                finish_frame(l);
                dpos[l] = 0;
            end
        end
        fs    = (pos[l] == 0);
        e_rdy = (occ[l] < depth_of[l]);
        e_ur  = fs && (occ[l] == 0);
        e_bs  = fs && (frm[l] == 0);
        check($sformatf("L%0d ready/block_start/underrun p%0d f%0d", l, pos[l], frm[l]),
              64'({rdy, bs, ur}), 64'({e_rdy, e_bs, e_ur}));
        if (fs) begin
            if (l == 0) frq0.push_back('{v: e_ur, idx: 8'(frm[l])});
            else        frq1.push_back('{v: e_ur, idx: 8'(frm[l])});
            drun[l] = 1'b1;
        end
        psh    = sv && e_rdy;
        pp     = fs && (occ[l] > 0);
        occ[l] = occ[l] + int'(psh) - int'(pp);
        pos[l]++;
        if (pos[l] == f) begin
            pos[l] = 0;
            frm[l] = (frm[l] == 191) ? 0 : frm[l] + 1;
        end
    endtask

    // Monitor: the only process that compares.
    always @(negedge clk) begin
        lane_step(0, rst0, sv0, rdy0, out0, bs0, ur0);
        lane_step(1, rst1, sv1, rdy1, out1, bs1, ur1);
        if (stim_done && !mon_done) begin
            check("L0 pairs_never_sent", 64'(expq0.size()), 64'd0);
            check("L1 pairs_never_sent", 64'(expq1.size()), 64'd0);
            mon_done = 1'b1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [23:0] l, input logic [23:0] r);
        int   n;
        logic acc;
        n = 0;
        sl0 = l; sr0 = r; sv0 = 1'b1;
        do begin
            acc = rdy0;
            cyc(1);
            n++;
        end while (!acc && n < 1000);
        if (!acc) begin
            $display("FAIL L0 handshake got=timeout exp=accept");
            $fatal(1, "lane 0 handshake timeout");
        end
        expq0.push_back({l, r});
        sv0 = 1'b0;
    endtask

    task automatic send1(input logic [15:0] l, input logic [15:0] r,
                         input logic [23:0] el, input logic [23:0] er);
        int   n;
        logic acc;
        n = 0;
        sl1 = l; sr1 = r; sv1 = 1'b1;
        do begin
            acc = rdy1;
            cyc(1);
            n++;
        end while (!acc && n < 2000);
        if (!acc) begin
            $display("FAIL L1 handshake got=timeout exp=accept");
            $fatal(1, "lane 1 handshake timeout");
        end
        expq1.push_back({el, er});
        sv1 = 1'b0;
    endtask

    task automatic wait_ur0();
        int n;
        n = 0;
        while (!ur0 && n < 2000) begin cyc(1); n++; end
        if (!ur0) begin
            $display("FAIL L0 wait_underrun got=none exp=pulse");
            $fatal(1, "lane 0 underrun wait expired");
        end
    endtask

    task automatic wait_ur1();
        int n;
        n = 0;
        while (!ur1 && n < 4000) begin cyc(1); n++; end
        if (!ur1) begin
            $display("FAIL L1 wait_underrun got=none exp=pulse");
            $fatal(1, "lane 1 underrun wait expired");
        end
    endtask

    initial begin
        cyc(1);
        fork
            begin : lane0
                cyc(3);
                rst0 = 1'b0;
                cyc(3 * 128);
                send0(24'h800001, 24'h000000);
                send0(24'h000001, 24'hFFFFFF);
                send0(24'h7FFFFF, 24'h800000);
                send0(24'hA5A5A5, 24'h5A5A5A);
                cyc(6 * 128);
                // Mid-frame burst: four fit, the rest wait for frame-start pops.
                wait_ur0();
                cyc(5);
                for (int i = 0; i < 6; i++)
                    send0(24'h100000 + 24'(i), 24'h200000 - 24'(i));
                cyc(8 * 128);
                // Push on the frame-start cycle of an empty FIFO: that frame still underruns.
                wait_ur0();
                send0(24'h0F0F0F, 24'hF0F0F0);
                cyc(180 * 128);
            end
            begin : lane1
                cyc(4);
                rst1 = 1'b0;
                cyc(384 + 10);
                send1(16'hFFFF, 16'h0001, 24'hFFFF00, 24'h000100);
                send1(16'h8000, 16'h7FFF, 24'h800000, 24'h7FFF00);
                cyc(4 * 384);
                wait_ur1();
                cyc(3);
                send1(16'h1111, 16'h2222, 24'h111100, 24'h222200);
                send1(16'h3333, 16'h4444, 24'h333300, 24'h444400);
                cyc(90 * 3 - 5);
                rst1 = 1'b1;
                cyc(4);
                rst1 = 1'b0;
                cyc(3 * 384);
                send1(16'h1234, 16'hFEDC, 24'h123400, 24'hFEDC00);
                cyc(3 * 384);
            end
        join
        stim_done = 1'b1;
        repeat (10) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
